// File: rtl/qx1_pkg.sv
// Shared types and sizes for the QX1 write-back path.
package qx1_pkg;
  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_W-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/qx1_wb_fifo.sv
// Small synchronous FIFO of write-back requests; extra pointer MSB separates full from empty.
module qx1_wb_fifo
  import qx1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  // a pop on the same edge frees the slot, so a push while full is still legal
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/qx1_writeback.sv
// GPR write-side master: arbitrates ALU vs buffered LSU results, registers the
// write port and tracks outstanding destinations in busy_mask.
module qx1_writeback
  import qx1_pkg::*;
#(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [REG_W-1:0]      alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_dest,
  input  logic [REG_W-1:0]      lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [REG_W-1:0]      reg_write_data,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  lsu_overrun
);
  wb_req_t              fifo_head, lsu_req, grant;
  logic                 fifo_full, fifo_empty, lsu_push;
  logic                 starve, alu_win, lsu_win, win;
  logic [3:0]           starve_cnt;
  logic [NUM_REGS-1:0]  busy_next;

  assign lsu_req = '{dest: lsu_dest, data: lsu_data};

  qx1_wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_push),
    .push_data (lsu_req),
    .pop       (lsu_win),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    starve    = !fifo_empty && (starve_cnt >= 4'(STARVE_LIMIT));
    alu_ready = !starve;
    lsu_ready = !fifo_full;
    lsu_push  = lsu_valid && !fifo_full;
    alu_win   = alu_valid && !starve;
    lsu_win   = !alu_win && !fifo_empty;
    win       = alu_win || lsu_win;
    grant     = alu_win ? '{dest: alu_dest, data: alu_data} : fifo_head;
  end

  // issue after clear so a same-edge set of the same bit wins
  always_comb begin
    busy_next = busy_mask;
    if (win)         busy_next[grant.dest] = 1'b0;
    if (issue_valid) busy_next[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt     <= '0;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      busy_mask      <= '0;
      lsu_overrun    <= 1'b0;
    end else begin
      if (lsu_win || fifo_empty)         starve_cnt <= '0;
      else if (alu_win && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      reg_write_en <= win;
      if (win) begin
        reg_write_dest <= grant.dest;
        reg_write_data <= grant.data;
      end
      busy_mask <= busy_next;
      if (lsu_valid && fifo_full) lsu_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qx1_writeback.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a queue-based reference model of the write-back rules.
module tb_qx1_writeback;
  import qx1_pkg::*;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [2:0]  alu_dest = '0, lsu_dest = '0, issue_dest = '0;
  logic [15:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, reg_write_en, lsu_overrun;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [7:0]  busy_mask;

  qx1_writeback #(.LSU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .busy_mask(busy_mask), .lsu_overrun(lsu_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // reference model state
  wb_req_t     mq[$];
  int          m_cnt;
  logic [7:0]  m_busy;
  logic        m_ovr, m_en, last_acc;
  logic [2:0]  m_dest;
  logic [15:0] m_data;
  logic [2:0]  pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete(); pend.delete();
    m_cnt = 0; m_busy = '0; m_ovr = 0; m_en = 0; m_dest = '0; m_data = '0; last_acc = 0;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask

  // One clock: check ready signals, advance the model, then check registered outputs.
  task automatic step();
    int pre;
    bit st, full, acc, popped;
    wb_req_t r;
    pre  = mq.size();
    st   = (pre != 0) && (m_cnt >= LIMIT);
    full = (pre == DEPTH);
    chk("alu_ready", alu_ready, !st);
    chk("lsu_ready", lsu_ready, !full);
    if (issue_valid)
      assert (!m_busy[issue_dest]) else $error("FAIL contract: issue to busy r%0d", issue_dest);
    acc = alu_valid && !st;
    popped = 0;
    m_en = 0;
    if (acc) begin
      m_en = 1; m_dest = alu_dest; m_data = alu_data;
    end else if (pre != 0) begin
      r = mq.pop_front();
      m_en = 1; m_dest = r.dest; m_data = r.data; popped = 1;
    end
    if (popped || pre == 0) m_cnt = 0;
    else if (acc && m_cnt < 15) m_cnt++;
    if (m_en) m_busy[m_dest] = 0;
    if (issue_valid) m_busy[issue_dest] = 1;
    if (lsu_valid) begin
      if (full) m_ovr = 1;
      else mq.push_back(wb_req_t'{dest: lsu_dest, data: lsu_data});
    end
    last_acc = acc;
    @(posedge clk); #1;
    chk("wr_en", reg_write_en, m_en);
    chk("wr_dest", reg_write_dest, m_dest);
    chk("wr_data", reg_write_data, m_data);
    chk("busy", busy_mask, m_busy);
    chk("overrun", lsu_overrun, m_ovr);
  endtask

  task automatic do_issue(input logic [2:0] r);
    idle(); issue_valid = 1; issue_dest = r; step(); issue_valid = 0;
  endtask

  task automatic pick(output logic [2:0] d);
    int idx;
    idx = $urandom_range(0, pend.size() - 1);
    d = pend[idx];
    pend.delete(idx);
  endtask

  initial begin
    logic [2:0] fr[$];
    logic [2:0] d;
    bit done;
    model_reset();
    #12;
    chk("rst_en", reg_write_en, 0);
    chk("rst_dest", reg_write_dest, 0);
    chk("rst_data", reg_write_data, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_ovr", lsu_overrun, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // ALU only
    do_issue(3);
    chk("alu_busy_set", busy_mask, 8'h08);
    alu_valid = 1; alu_dest = 3; alu_data = 16'h1234; step(); idle();
    chk("alu_wr", {reg_write_en, 4'(reg_write_dest), reg_write_data}, {1'b1, 4'd3, 16'h1234});
    chk("alu_busy_clr", busy_mask, 8'h00);

    // LSU only: push edge, then pop edge
    do_issue(5);
    lsu_valid = 1; lsu_dest = 5; lsu_data = 16'hBEEF; step(); idle();
    chk("lsu_not_yet", reg_write_en, 0);
    step();
    chk("lsu_wr", {reg_write_en, 4'(reg_write_dest), reg_write_data}, {1'b1, 4'd5, 16'hBEEF});
    chk("lsu_busy_clr", busy_mask, 8'h00);

    // simultaneous ALU and LSU
    do_issue(1); do_issue(2);
    alu_valid = 1; alu_dest = 1; alu_data = 16'h0001;
    lsu_valid = 1; lsu_dest = 2; lsu_data = 16'h0002;
    chk("sim_alu_ready", alu_ready, 1);
    step(); idle();
    chk("sim_first", reg_write_dest, 1);
    step();
    chk("sim_second", {reg_write_en, 4'(reg_write_dest)}, {1'b1, 4'd2});

    // starvation
    do_issue(0); do_issue(1); do_issue(2); do_issue(3); do_issue(6); do_issue(4);
    lsu_valid = 1; lsu_dest = 4; lsu_data = 16'h4444; step(); idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_dest = 3'(i); alu_data = 16'(16'h100 + i); step();
    end
    alu_dest = 6; alu_data = 16'h0666;
    chk("starve_block", alu_ready, 0);
    step();
    chk("starve_lsu_wr", {4'(reg_write_dest), reg_write_data}, {4'd4, 16'h4444});
    chk("starve_release", alu_ready, 1);
    step(); idle();
    chk("starve_alu_wr", reg_write_dest, 6);

    // FIFO full and overrun, then reset mid-operation
    do_issue(0); do_issue(1); do_issue(2); do_issue(4); do_issue(5); do_issue(7);
    alu_valid = 1; alu_dest = 0; alu_data = 16'hA000; lsu_valid = 1; lsu_dest = 4; lsu_data = 16'h0444; step();
    alu_dest = 1; alu_data = 16'hA001; lsu_dest = 5; lsu_data = 16'h0555; step();
    chk("full_ready", lsu_ready, 0);
    alu_dest = 2; alu_data = 16'hA002; lsu_dest = 7; lsu_data = 16'hDEAD; step(); idle();
    chk("overrun_set", lsu_overrun, 1);
    chk("full_busy", busy_mask, 8'hB0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out", {reg_write_en, 4'(reg_write_dest), reg_write_data, busy_mask, lsu_overrun},
        {1'b0, 4'd0, 16'h0, 8'h0, 1'b0});
    chk("mid_rst_fifo", lsu_ready, 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (4) step();
    chk("post_rst_quiet", reg_write_en, 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      issue_valid = 0; lsu_valid = 0;
      if (!alu_valid && pend.size() != 0 && $urandom_range(0, 2) != 0) begin
        pick(d); alu_valid = 1; alu_dest = d; alu_data = 16'($urandom);
      end
      if (pend.size() != 0 && mq.size() < DEPTH && $urandom_range(0, 1) != 0) begin
        pick(d); lsu_valid = 1; lsu_dest = d; lsu_data = 16'($urandom);
      end
      if ($urandom_range(0, 1) != 0) begin
        fr.delete();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) fr.push_back(3'(i));
        if (fr.size() != 0) begin
          issue_valid = 1; issue_dest = fr[$urandom_range(0, fr.size() - 1)];
        end
      end
      step();
      if (issue_valid) pend.push_back(issue_dest);
      if (last_acc) alu_valid = 0;
    end

    // drain every outstanding result
    issue_valid = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      lsu_valid = 0;
      if (!alu_valid && pend.size() != 0) begin
        pick(d); alu_valid = 1; alu_dest = d; alu_data = 16'($urandom);
      end
      step();
      if (last_acc) alu_valid = 0;
      done = (pend.size() == 0) && !alu_valid && (mq.size() == 0);
    end
    chk("drain_done", done, 1);
    idle(); step();
    chk("drain_busy", busy_mask, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
